// File: rtl/coin_pkg.sv
// Shared types and constants for the coin change dispenser.
package coin_pkg;

  // Coin codes on the wire; matches the coin acceptor encoding.
  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_1    = 2'b01,
    COIN_3    = 2'b10,
    COIN_5    = 2'b11
  } coin_t;

  localparam int unsigned COIN_VAL_1 = 1;
  localparam int unsigned COIN_VAL_3 = 3;
  localparam int unsigned COIN_VAL_5 = 5;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    HOLD,
    GAP,
    DONE
  } disp_state_t;

endpackage

// File: rtl/coin_selector.sv
// Greedy coin pick (5, then 3, then 1) limited by what is still in stock.
module coin_selector
  import coin_pkg::*;
#(
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned STOCK_W  = 4
) (
  input  logic [CREDIT_W-1:0] remaining_i,
  input  logic [STOCK_W-1:0]  stock1_i,
  input  logic [STOCK_W-1:0]  stock3_i,
  input  logic [STOCK_W-1:0]  stock5_i,
  output coin_t               coin_o,
  output logic [CREDIT_W-1:0] value_o,
  output logic                none_fit_o
);

  // Largest denomination that fits the remainder and is still stocked.
  always_comb begin
    coin_o     = COIN_NONE;
    value_o    = '0;
    none_fit_o = 1'b0;
    if (remaining_i >= CREDIT_W'(COIN_VAL_5) && stock5_i != '0) begin
      coin_o  = COIN_5;
      value_o = CREDIT_W'(COIN_VAL_5);
    end else if (remaining_i >= CREDIT_W'(COIN_VAL_3) && stock3_i != '0) begin
      coin_o  = COIN_3;
      value_o = CREDIT_W'(COIN_VAL_3);
    end else if (remaining_i >= CREDIT_W'(COIN_VAL_1) && stock1_i != '0) begin
      coin_o  = COIN_1;
      value_o = CREDIT_W'(COIN_VAL_1);
    end else begin
      none_fit_o = 1'b1;
    end
  end

endmodule

// File: rtl/coin_change_dispenser.sv
// Pays out a requested amount as a pulse/gap coin stream from finite per-denomination stock.
module coin_change_dispenser
  import coin_pkg::*;
#(
  parameter int unsigned CREDIT_W     = 4,
  parameter int unsigned STOCK_W      = 4,
  parameter int unsigned HOLD_CYCLES  = 1,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned INIT_STOCK_1 = 8,
  parameter int unsigned INIT_STOCK_3 = 8,
  parameter int unsigned INIT_STOCK_5 = 8
) (
  input  logic                clock,
  input  logic                reset_N,
  input  logic                start,
  input  logic [CREDIT_W-1:0] amount,
  input  logic                refill,
  output logic                ready,
  output logic                busy,
  output logic [1:0]          CoinValue,
  output logic                done,
  output logic                short_change,
  output logic [CREDIT_W-1:0] remaining,
  output logic [STOCK_W-1:0]  stock1,
  output logic [STOCK_W-1:0]  stock3,
  output logic [STOCK_W-1:0]  stock5
);

  localparam int unsigned CntMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  disp_state_t         state_q, state_d;
  coin_t               coin_q, coin_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CREDIT_W-1:0] rem_q, rem_d;
  logic                short_q, short_d;
  logic [STOCK_W-1:0]  s1_q, s1_d, s3_q, s3_d, s5_q, s5_d;

  coin_t               sel_coin;
  logic [CREDIT_W-1:0] sel_value;
  logic                sel_none;

  coin_selector #(
    .CREDIT_W (CREDIT_W),
    .STOCK_W  (STOCK_W)
  ) u_selector (
    .remaining_i (rem_q),
    .stock1_i    (s1_q),
    .stock3_i    (s3_q),
    .stock5_i    (s5_q),
    .coin_o      (sel_coin),
    .value_o     (sel_value),
    .none_fit_o  (sel_none)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath registers: latched coin, hold/gap counter, remainder, flag, stocks.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      coin_q  <= COIN_NONE;
      cnt_q   <= '0;
      rem_q   <= '0;
      short_q <= 1'b0;
      s1_q    <= STOCK_W'(INIT_STOCK_1);
      s3_q    <= STOCK_W'(INIT_STOCK_3);
      s5_q    <= STOCK_W'(INIT_STOCK_5);
    end else begin
      coin_q  <= coin_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      short_q <= short_d;
      s1_q    <= s1_d;
      s3_q    <= s3_d;
      s5_q    <= s5_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    coin_d  = coin_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    short_d = short_q;
    s1_d    = s1_q;
    s3_d    = s3_q;
    s5_d    = s5_q;
    unique case (state_q)
      IDLE: begin
        // Refill lands in the same edge as start, so the payout sees full stock.
        if (refill) begin
          s1_d = STOCK_W'(INIT_STOCK_1);
          s3_d = STOCK_W'(INIT_STOCK_3);
          s5_d = STOCK_W'(INIT_STOCK_5);
        end
        if (start) begin
          rem_d   = amount;
          short_d = 1'b0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (rem_q == '0) begin
          state_d = DONE;
        end else if (sel_none) begin
          short_d = 1'b1;
          state_d = DONE;
        end else begin
          coin_d  = sel_coin;
          rem_d   = rem_q - sel_value;
          cnt_d   = '0;
          state_d = HOLD;
          unique case (sel_coin)
            COIN_5:  s5_d = s5_q - STOCK_W'(1);
            COIN_3:  s3_d = s3_q - STOCK_W'(1);
            default: s1_d = s1_q - STOCK_W'(1);
          endcase
        end
      end
      HOLD: begin
        if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      GAP: begin
        if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = SELECT;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and registers only.
  always_comb begin
    ready        = (state_q == IDLE);
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
    CoinValue    = (state_q == HOLD) ? coin_q : COIN_NONE;
    short_change = short_q;
    remaining    = rem_q;
    stock1       = s1_q;
    stock3       = s3_q;
    stock5       = s5_q;
  end

endmodule
